operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
// - ID-stage operand source, directly downstream of the ID register-address decoder: consumes its
//   read enables/addresses, returns two 32-bit operands to the ID/EX latch.
// - Holds the 32x32 GPR file (write port driven by WB), forwards from EX and MEM results, and
//   raises a load-use stall request to the pipeline controller. Counts stall cycles for debug.
// PARAMETERS
// - DATA_WIDTH  32  operand / register width
// - ADDR_WIDTH  5   register index width (matches REG_ADDR_BUS)
// - REG_COUNT   32  number of GPRs; index 0 is hard-wired zero
// PORTS
// - clk             in   1   system clock, all state on rising edge
// - rst             in   1   synchronous reset, active high
// - read_en_1       in   1   read port 1 enable (from ID decoder)
// - read_addr_1     in   5   read port 1 index
// - read_en_2       in   1   read port 2 enable
// - read_addr_2     in   5   read port 2 index
// - ex_write_en     in   1   EX-stage instruction writes a GPR
// - ex_write_addr   in   5   EX destination index
// - ex_write_data   in   32  EX ALU result
// - ex_is_load      in   1   EX instruction is LB/LBU/LW (data not yet available)
// - mem_write_en    in   1   MEM-stage instruction writes a GPR
// - mem_write_addr  in   5   MEM destination index
// - mem_write_data  in   32  MEM result (load data or passed ALU result)
// - wb_write_en     in   1   WB write strobe into GPR file
// - wb_write_addr   in   5   WB destination index
// - wb_write_data   in   32  WB data
// - operand_1       out  32  resolved value for port 1
// - operand_2       out  32  resolved value for port 2
// - stall_req       out  1   load-use hazard; hold PC/IF/ID, bubble into EX
// - stall_count     out  32  saturating count of cycles with stall_req=1
// BEHAVIOUR
// - Reset: all GPRs <= 0, stall_count <= 0; while rst=1 operand_1/2=0, stall_req=0.
// - GPR write: on clk edge when wb_write_en=1 and wb_write_addr!=0; writes to index 0 dropped.
// - Operand select (combinational, zero latency), per port p, first match wins:
//   1. read_en_p=0 or read_addr_p=0 -> 0
//   2. ex_write_en & ex_write_addr==read_addr_p & !ex_is_load -> ex_write_data
//   3. mem_write_en & mem_write_addr==read_addr_p -> mem_write_data
//   4. wb_write_en & wb_write_addr==read_addr_p -> wb_write_data (same-cycle write bypass)
//   5. else GPR[read_addr_p]
// - Load-use: stall_req=1 iff ex_write_en & ex_is_load & ex_write_addr!=0 and, for either port,
//   read_en_p & read_addr_p==ex_write_addr. Under stall the port uses rules 3-5 (EX skipped).
// - stall_req purely combinational; no internal hold state. Controller re-presents the same
//   instruction next cycle; load is then in MEM and rule 3 resolves it.
// - stall_count: +1 per clk with stall_req=1 and rst=0; saturates at 32'hFFFF_FFFF, no wrap.
// - Both ports may read the same index; both resolve identically.
// - EX and MEM targeting the same index: EX (younger) wins. Rule 2 masked only by ex_is_load.
// - Reset asserted mid-stall: stall_req drops same cycle, counter clears at next edge.
// STRUCTURE
// - Shared defines (bus.v): REG_ADDR_BUS, DATA_BUS, REG_ZERO index constant.
// - One sub-module: gpr_file (storage, synchronous reset, WB write, rules 1/4/5 read mux x2).
// - Top level: forwarding priority mux, hazard compare, stall counter.
// TESTING
// - Reset then read r5/r6 -> operands 0, stall_req 0, stall_count 0.
// - WB write r3=0x1234_5678, same cycle read r3 -> 0x1234_5678 (bypass); next cycle still same.
// - WB write r0=0xFFFF_FFFF, read r0 -> 0; read_en_1=0 on r3 -> operand_1 0.
// - r4: EX=0xA, MEM=0xB, WB=0xC all targeting r4 -> operand 0xA; drop EX -> 0xB; drop MEM -> 0xC.
// - EX load to r7, port 2 reads r7 -> stall_req 1, stall_count 0->1; next cycle load in MEM
//   data 0x55 -> operand_2 0x55, stall_req 0; EX load to r0 -> no stall.
// - Preload stall_count near max via 3 consecutive stalls after forced top value -> holds at
//   0xFFFF_FFFF; assert rst mid-stall -> stall_req 0 same cycle, count 0 after edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the ID-stage operand fetch block.
// Sized to the GPR file and the 32-bit datapath.
package operand_fetch_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 5;
  localparam int unsigned REG_COUNT      = 32;
  localparam int unsigned NUM_READ_PORTS = 2;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO        = '0;
  localparam data_t     STALL_COUNT_MAX = '1;

  // Where a read port's operand comes from this cycle.
  typedef enum logic [1:0] {
    SrcZero,
    SrcEx,
    SrcMem,
    SrcFile
  } fwd_src_e;

  function automatic logic addr_hit(logic en, reg_addr_t write_addr, reg_addr_t read_addr);
    return en && (write_addr == read_addr);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle between the ID decoder / EX / MEM / WB stages and the operand fetch block.
// master = pipeline side, slave = operand_fetch.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic      read_en_1;
  reg_addr_t read_addr_1;
  logic      read_en_2;
  reg_addr_t read_addr_2;

  logic      ex_write_en;
  reg_addr_t ex_write_addr;
  data_t     ex_write_data;
  logic      ex_is_load;

  logic      mem_write_en;
  reg_addr_t mem_write_addr;
  data_t     mem_write_data;

  logic      wb_write_en;
  reg_addr_t wb_write_addr;
  data_t     wb_write_data;

  data_t     operand_1;
  data_t     operand_2;
  logic      stall_req;
  data_t     stall_count;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    output ex_write_en, ex_write_addr, ex_write_data, ex_is_load,
    output mem_write_en, mem_write_addr, mem_write_data,
    output wb_write_en, wb_write_addr, wb_write_data,
    input  operand_1, operand_2, stall_req, stall_count
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  ex_write_en, ex_write_addr, ex_write_data, ex_is_load,
    input  mem_write_en, mem_write_addr, mem_write_data,
    input  wb_write_en, wb_write_addr, wb_write_data,
    output operand_1, operand_2, stall_req, stall_count
  );

endinterface

// File: rtl/operand_fetch_gpr_file.sv
// 32x32 GPR storage with a single WB write port and two combinational read ports.
// Reads return zero for disabled ports / r0 and bypass a same-cycle WB write.
module operand_fetch_gpr_file
  import operand_fetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_write_en,
  input  reg_addr_t                 wb_write_addr,
  input  data_t                     wb_write_data,
  input  logic [NUM_READ_PORTS-1:0] read_en,
  input  reg_addr_t                 read_addr [NUM_READ_PORTS],
  output data_t                     read_data [NUM_READ_PORTS]
);

  data_t regs_q [REG_COUNT];

  // Entry 0 is reset and never written, so it reads back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_write_en && (wb_write_addr != REG_ZERO)) begin
      regs_q[wb_write_addr] <= wb_write_data;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
      read_data[p] = '0;
      if (read_en[p] && (read_addr[p] != REG_ZERO)) begin
        if (addr_hit(wb_write_en, wb_write_addr, read_addr[p])) begin
          read_data[p] = wb_write_data;
        end else begin
          read_data[p] = regs_q[read_addr[p]];
        end
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// ID-stage operand source: GPR file, EX/MEM forwarding, load-use stall detection
// and a saturating stall-cycle counter for debug.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input logic            clk,
  input logic            rst,
  operand_fetch_if.slave bus
);

  logic [NUM_READ_PORTS-1:0] rd_en;
  reg_addr_t                 rd_addr   [NUM_READ_PORTS];
  data_t                     file_data [NUM_READ_PORTS];

  assign rd_en      = {bus.read_en_2, bus.read_en_1};
  assign rd_addr[0] = bus.read_addr_1;
  assign rd_addr[1] = bus.read_addr_2;

  operand_fetch_gpr_file u_gpr_file (
    .clk           (clk),
    .rst           (rst),
    .wb_write_en   (bus.wb_write_en),
    .wb_write_addr (bus.wb_write_addr),
    .wb_write_data (bus.wb_write_data),
    .read_en       (rd_en),
    .read_addr     (rd_addr),
    .read_data     (file_data)
  );

  fwd_src_e                  src      [NUM_READ_PORTS];
  data_t                     operand  [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] load_use;
  logic                      ex_fwd_ok;
  logic                      load_pending;
  logic                      stall_req;

  // A load in EX has no data yet: it is never a forwarding source, and any
  // reader of its destination must stall until the load reaches MEM.
  always_comb begin
    ex_fwd_ok    = bus.ex_write_en && !bus.ex_is_load;
    load_pending = bus.ex_write_en && bus.ex_is_load && (bus.ex_write_addr != REG_ZERO);
    for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
      src[p]      = SrcFile;
      operand[p]  = '0;
      load_use[p] = load_pending && rd_en[p] && (rd_addr[p] == bus.ex_write_addr);

      if (!rd_en[p] || (rd_addr[p] == REG_ZERO)) begin
        src[p] = SrcZero;
      end else if (addr_hit(ex_fwd_ok, bus.ex_write_addr, rd_addr[p])) begin
        src[p] = SrcEx;
      end else if (addr_hit(bus.mem_write_en, bus.mem_write_addr, rd_addr[p])) begin
        src[p] = SrcMem;
      end

      unique case (src[p])
        SrcZero: operand[p] = '0;
        SrcEx:   operand[p] = bus.ex_write_data;
        SrcMem:  operand[p] = bus.mem_write_data;
        SrcFile: operand[p] = file_data[p];
        default: operand[p] = '0;
      endcase

      if (rst) begin
        operand[p] = '0;
      end
    end
    stall_req = !rst && (|load_use);
  end

  assign bus.operand_1 = operand[0];
  assign bus.operand_2 = operand[1];
  assign bus.stall_req = stall_req;

  data_t stall_count_q;
  data_t stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_req && (stall_count_q != STALL_COUNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;

endmodule
